// File: rtl/ram_pkg.sv
// Shared definitions for the RAM request controller: word geometry and FSM states.
package ram_pkg;

  localparam int RAM_DW = 8;
  localparam int RAM_AW = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RSP     = 2'd2
  } ram_ctrl_state_t;

endpackage

// File: rtl/ram_ctrl_rsp_buf.sv
// Response holding register: a load fills it and raises valid; valid falls on the
// valid&ready handshake, while the held word keeps its last value.
module ram_ctrl_rsp_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_data,
  input  logic         i_ready,
  output logic         o_valid,
  output logic [W-1:0] o_data
);

  logic         r_valid;
  logic [W-1:0] r_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/ram_ctrl.sv
// Valid/ready front end for the 8-entry synchronous RAM. Define RAM_CTRL_WR_ACK_EN to
// make writes return an acknowledgement response (adds the rsp_is_wr port).
//
// Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
// the source holds its payload stable while valid is 1 and ready is 0.
module ram_ctrl
  import ram_pkg::*;
#(
  parameter int DW = RAM_DW,
  parameter int AW = RAM_AW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_wr,
  input  logic [AW-1:0]   req_addr,
  input  logic [DW-1:0]   req_wdata,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [DW-1:0]   rsp_rdata,
  output logic            ram_en,
  output logic            ram_wr,
  output logic [AW-1:0]   ram_addr,
  output logic [DW-1:0]   ram_wdata,
  input  logic [DW-1:0]   ram_rdata,
`ifdef RAM_CTRL_WR_ACK_EN
  output logic            rsp_is_wr,
`endif
  output ram_ctrl_state_t dbg_state
);

`ifdef RAM_CTRL_WR_ACK_EN
  localparam int BW = DW + 1;
`else
  localparam int BW = DW;
`endif

  ram_ctrl_state_t r_state;
  ram_ctrl_state_t w_next;
  logic            w_accept;
  logic            w_load;
  logic [BW-1:0]   w_load_word;
  logic [BW-1:0]   w_rsp_word;

  // Ready is gated by rst_n so nothing can reach the RAM while reset is held.
  assign req_ready = rst_n && (r_state == IDLE);
  assign w_accept  = req_valid && req_ready;

  assign ram_en    = w_accept;
  assign ram_wr    = req_wr;
  assign ram_addr  = req_addr;
  assign ram_wdata = req_wdata;

  always_comb begin
    w_next      = r_state;
    w_load      = 1'b0;
    w_load_word = '0;
    case (r_state)
      IDLE: begin
        if (w_accept && !req_wr) begin
          w_next = RD_WAIT;
        end
`ifdef RAM_CTRL_WR_ACK_EN
        else if (w_accept) begin
          w_next      = RSP;
          w_load      = 1'b1;
          w_load_word = {1'b1, req_wdata};
        end
`endif
      end
      RD_WAIT: begin
        // RAM data_out is valid only this cycle; it clears at the next edge.
        w_next = RSP;
        w_load = 1'b1;
`ifdef RAM_CTRL_WR_ACK_EN
        w_load_word = {1'b0, ram_rdata};
`else
        w_load_word = ram_rdata;
`endif
      end
      RSP: begin
        if (rsp_ready) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  ram_ctrl_rsp_buf #(.W(BW)) u_rsp_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_load),
    .i_data  (w_load_word),
    .i_ready (rsp_ready),
    .o_valid (rsp_valid),
    .o_data  (w_rsp_word)
  );

  assign rsp_rdata = w_rsp_word[DW-1:0];
`ifdef RAM_CTRL_WR_ACK_EN
  assign rsp_is_wr = w_rsp_word[DW];
`endif

  assign dbg_state = r_state;

endmodule

// File: tb/tb_ram_ctrl.sv
// Bench for ram_ctrl with a behavioural 8-entry RAM attached and a reference memory
// array; builds with or without RAM_CTRL_WR_ACK_EN.
module tb_ram_ctrl;
  import ram_pkg::*;

  localparam int DW = RAM_DW;
  localparam int AW = RAM_AW;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic            req_wr = 1'b0;
  logic [AW-1:0]   req_addr = '0;
  logic [DW-1:0]   req_wdata = '0;
  logic            rsp_valid;
  logic            rsp_ready = 1'b0;
  logic [DW-1:0]   rsp_rdata;
  logic            ram_en;
  logic            ram_wr;
  logic [AW-1:0]   ram_addr;
  logic [DW-1:0]   ram_wdata;
  logic [DW-1:0]   ram_rdata;
`ifdef RAM_CTRL_WR_ACK_EN
  logic            rsp_is_wr;
`endif
  ram_ctrl_state_t dbg_state;

  always #5 clk = ~clk;

  ram_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_wr    (req_wr),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .ram_en    (ram_en),
    .ram_wr    (ram_wr),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
`ifdef RAM_CTRL_WR_ACK_EN
    .rsp_is_wr (rsp_is_wr),
`endif
    .dbg_state (dbg_state)
  );

  // Synchronous RAM: registered read data, data_out cleared on any cycle with en=0.
  logic [DW-1:0] ram_mem [8];
  logic [DW-1:0] ram_dout;
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_wr) ram_mem[ram_addr] <= ram_wdata;
      else        ram_dout <= ram_mem[ram_addr];
    end else begin
      ram_dout <= '0;
    end
  end
  assign ram_rdata = ram_dout;

  // Reference model: contents the client expects the RAM to hold.
  logic [DW-1:0] ref_mem [8];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Consume a response: hold rsp_ready low for 'stall' cycles, then handshake.
  task automatic get_rsp(input logic [DW-1:0] exp, input logic is_wr, input int stall);
    rsp_ready = 1'b0;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("stall_rsp_valid", rsp_valid, 1);
      check("stall_rsp_rdata", rsp_rdata, exp);
      check("stall_req_ready", req_ready, 0);
      check("stall_ram_en", ram_en, 0);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("rsp_valid", rsp_valid, 1);
    check("rsp_rdata", rsp_rdata, exp);
`ifdef RAM_CTRL_WR_ACK_EN
    check("rsp_is_wr", rsp_is_wr, is_wr);
`else
    check("rsp_kind_read", is_wr, 0);
`endif
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    check("post_rsp_valid", rsp_valid, 0);
    check("post_req_ready", req_ready, 1);
    check("post_rsp_hold", rsp_rdata, exp);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid = 1'b1;
    req_wr    = 1'b1;
    req_addr  = a;
    req_wdata = d;
    @(negedge clk);
    check("wr_req_ready", req_ready, 1);
    check("wr_ram_en", ram_en, 1);
    check("wr_ram_wr", ram_wr, 1);
    check("wr_ram_addr", ram_addr, a);
    check("wr_ram_wdata", ram_wdata, d);
    @(posedge clk); #1;
    req_valid = 1'b0;
    ref_mem[a] = d;
`ifdef RAM_CTRL_WR_ACK_EN
    get_rsp(d, 1'b1, $urandom_range(0, 2));
`else
    check("wr_no_rsp", rsp_valid, 0);
    check("wr_still_ready", req_ready, 1);
`endif
  endtask

  task automatic do_read(input logic [AW-1:0] a, input int stall);
    logic [DW-1:0] exp;
    exp = ref_mem[a];
    req_valid = 1'b1;
    req_wr    = 1'b0;
    req_addr  = a;
    req_wdata = DW'($urandom);
    @(negedge clk);
    check("rd_req_ready", req_ready, 1);
    check("rd_ram_en", ram_en, 1);
    check("rd_ram_wr", ram_wr, 0);
    check("rd_ram_addr", ram_addr, a);
    @(posedge clk); #1;
    // A new command presented while the read is outstanding must be ignored.
    req_wr    = 1'($urandom);
    req_addr  = AW'($urandom);
    req_wdata = DW'($urandom);
    @(negedge clk);
    check("rdw_rsp_valid", rsp_valid, 0);
    check("rdw_req_ready", req_ready, 0);
    check("rdw_ram_en", ram_en, 0);
    check("rdw_state", dbg_state, RD_WAIT);
    @(posedge clk); #1;
    get_rsp(exp, 1'b0, stall);
  endtask

  initial begin
    // Reset with a command already offered: nothing may reach the RAM.
    req_valid = 1'b1;
    req_wr    = 1'b1;
    req_addr  = 3'd2;
    req_wdata = 8'hAA;
    #2;
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_ram_en", ram_en, 0);
    check("rst_state", dbg_state, IDLE);
    repeat (2) @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rel_req_ready", req_ready, 1);

    // Single write then read back.
    do_write(3'd7, 8'd19);
    do_read(3'd7, 0);

    // Three back-to-back writes, then read each back.
    do_write(3'd7, 8'd19);
    do_write(3'd6, 8'd55);
    do_write(3'd5, 8'd20);
    do_read(3'd7, 0);
    do_read(3'd6, 0);
    do_read(3'd5, 0);

    // Response held under backpressure.
    do_read(3'd6, 4);

    // Reset while a read waits on the RAM.
    req_valid = 1'b1;
    req_wr    = 1'b0;
    req_addr  = 3'd6;
    @(posedge clk); #1;
    check("mid_state", dbg_state, RD_WAIT);
    rst_n = 1'b0;
    #1;
    check("mid_rst_rsp_valid", rsp_valid, 0);
    check("mid_rst_req_ready", req_ready, 0);
    check("mid_rst_ram_en", ram_en, 0);
    check("mid_rst_rsp_rdata", rsp_rdata, 0);
    repeat (2) begin
      @(posedge clk); #1;
      check("mid_rst_hold_valid", rsp_valid, 0);
      check("mid_rst_hold_en", ram_en, 0);
    end
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      check("post_rst_no_rsp", rsp_valid, 0);
      check("post_rst_ready", req_ready, 1);
    end
    do_read(3'd6, 1);

    // RAM idle for a while so its data_out is cleared before the read.
    repeat (3) @(posedge clk);
    #1;
    do_read(3'd5, 0);

    // Write acknowledge path (read response flagged as non-write in either build).
    do_write(3'd3, 8'd55);
    do_read(3'd3, 0);

    // Randomized traffic over a fully initialised memory.
    for (int a = 0; a < 8; a++) do_write(AW'(a), DW'($urandom));
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 1) == 1) begin
        do_write(AW'($urandom_range(0, 7)), DW'($urandom));
      end else begin
        do_read(AW'($urandom_range(0, 7)), $urandom_range(0, 3));
      end
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
